// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq -- fetch sequencer for an 8-bit programmable counter.
//
// Drives the counter's en/load/load_val/oe controls, arbitrates the
// counter's tri-state output onto a shared bus through bus_req/bus_gnt,
// runs bursts of fetches, applies queued jumps in place of increments and
// reports each fetched address.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin a burst (sampled in IDLE only)
//   halt               stop after the current fetch completes
//   jump_req/jump_addr queue a jump to jump_addr
//   bus_gnt            bus grant from the system arbiter
//   pc_q               counter value
//   pc_en, pc_load,
//   pc_load_val, pc_oe counter controls
//   bus_req            bus request
//   fetch_valid        fetch_addr valid this cycle
//   fetch_addr         fetched address (pc_q)
//   busy               any state other than IDLE
//   err                sticky grant-timeout flag
//
// Optional feature: define PC_FETCH_TIMEOUT_EN to abort a request after
// GNT_TIMEOUT consecutive ungranted REQ cycles (sets err). Without it REQ
// waits indefinitely and err is tied to 0.

module pc_fetch_seq #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned BURST_LEN   = 0,
   parameter int unsigned GNT_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt,
   input  logic             jump_req,
   input  logic [WIDTH-1:0] jump_addr,
   input  logic             bus_gnt,
   input  logic [WIDTH-1:0] pc_q,
   output logic             pc_en,
   output logic             pc_load,
   output logic [WIDTH-1:0] pc_load_val,
   output logic             pc_oe,
   output logic             bus_req,
   output logic             fetch_valid,
   output logic [WIDTH-1:0] fetch_addr,
   output logic             busy,
   output logic             err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_REQ,
      ST_DRIVE,
      ST_STEP
   } state_t;

   localparam logic [7:0] BURST_CMP = 8'(BURST_LEN);

   // Elaboration-time parameter sanity check.
   if (WIDTH == 0 || BURST_LEN > 255 || GNT_TIMEOUT == 0) begin : g_param_check
      $error("pc_fetch_seq: illegal parameter value");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_jmp_pend;
   logic [WIDTH-1:0] r_jmp_addr;
   logic             r_run;
   logic             r_halt_pend;
   logic [7:0]       r_fcnt;
   logic [7:0]       w_fcnt_inc;
   logic             w_burst_done;
   logic             w_start_acc;
   logic             w_idle_load;
   logic             w_enter_idle;
   logic             w_tmo_hit;

   assign w_fcnt_inc   = r_fcnt + 8'd1;
   assign w_burst_done = (BURST_LEN != 0) && (w_fcnt_inc == BURST_CMP);
   assign w_start_acc  = (r_state == ST_IDLE) && start;
   // A jump arriving together with start is taken before the first fetch;
   // its address is captured at the same edge, so LOAD sees it.
   assign w_idle_load  = (r_state == ST_IDLE) && (r_jmp_pend || (jump_req && start));
   assign w_enter_idle = (w_state_nxt == ST_IDLE) && (r_state != ST_IDLE);
   assign fetch_addr   = pc_q;

`ifdef PC_FETCH_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(GNT_TIMEOUT + 1);

   logic [TMO_W-1:0] r_tmo;
   logic             r_err;

   assign w_tmo_hit = (r_state == ST_REQ) && !bus_gnt &&
                      (r_tmo == TMO_W'(GNT_TIMEOUT - 1));
   assign err       = r_err;

   // Held at zero outside REQ, so every entry to REQ restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state != ST_REQ)
            r_tmo <= '0;
         else if (!bus_gnt)
            r_tmo <= r_tmo + TMO_W'(1);
         if (w_start_acc)
            r_err <= 1'b0;
         else if (w_tmo_hit)
            r_err <= 1'b1;
      end
   end
`else
   assign w_tmo_hit = 1'b0;
   assign err       = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      pc_en       = 1'b0;
      pc_load     = 1'b0;
      pc_load_val = '0;
      pc_oe       = 1'b0;
      bus_req     = 1'b0;
      fetch_valid = 1'b0;
      busy        = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (w_idle_load)
               w_state_nxt = ST_LOAD;
            else if (start)
               w_state_nxt = ST_REQ;
         end
         ST_LOAD: begin
            pc_load     = 1'b1;
            pc_load_val = r_jmp_addr;
            w_state_nxt = r_run ? ST_REQ : ST_IDLE;
         end
         ST_REQ: begin
            bus_req = 1'b1;
            if (bus_gnt)
               w_state_nxt = ST_DRIVE;
            else if (w_tmo_hit)
               w_state_nxt = ST_IDLE;
         end
         ST_DRIVE: begin
            bus_req     = 1'b1;
            pc_oe       = bus_gnt;
            fetch_valid = bus_gnt;
            w_state_nxt = bus_gnt ? ST_STEP : ST_REQ;
         end
         ST_STEP: begin
            if (r_jmp_pend) begin
               pc_load     = 1'b1;
               pc_load_val = r_jmp_addr;
            end else begin
               pc_en = 1'b1;
            end
            w_state_nxt = (r_halt_pend || w_burst_done) ? ST_IDLE : ST_REQ;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_jmp_pend  <= 1'b0;
         r_jmp_addr  <= '0;
         r_run       <= 1'b0;
         r_halt_pend <= 1'b0;
         r_fcnt      <= '0;
      end else begin
         // A new request beats a same-cycle consume.
         if (jump_req) begin
            r_jmp_pend <= 1'b1;
            r_jmp_addr <= jump_addr;
         end else if (pc_load) begin
            r_jmp_pend <= 1'b0;
         end
         // Any accepted start (including one that first takes a jump)
         // begins a fresh burst count.
         if (w_start_acc) begin
            r_run  <= 1'b1;
            r_fcnt <= '0;
         end
         if (r_state == ST_STEP)
            r_fcnt <= w_fcnt_inc;
         if (halt && busy)
            r_halt_pend <= 1'b1;
         if (w_enter_idle) begin
            r_run       <= 1'b0;
            r_halt_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_seq.sv
module tb_pc_fetch_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pc_rst_n = 1'b0;
   logic       start = 1'b0;
   logic       halt = 1'b0;
   logic       jump_req = 1'b0;
   logic [7:0] jump_addr = 8'h00;
   logic       bus_gnt = 1'b0;

   // Instance with BURST_LEN=3
   logic       en_3, ld_3, oe_3, req_3, fv_3, busy_3, err_3;
   logic [7:0] lv_3, fa_3, q_3;
   // Instance with BURST_LEN=0 (unbounded)
   logic       en_0, ld_0, oe_0, req_0, fv_0, busy_0, err_0;
   logic [7:0] lv_0, fa_0, q_0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_fetch_seq #(.WIDTH(8), .BURST_LEN(3), .GNT_TIMEOUT(15)) u_b3 (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
      .jump_req(jump_req), .jump_addr(jump_addr), .bus_gnt(bus_gnt),
      .pc_q(q_3), .pc_en(en_3), .pc_load(ld_3), .pc_load_val(lv_3),
      .pc_oe(oe_3), .bus_req(req_3), .fetch_valid(fv_3),
      .fetch_addr(fa_3), .busy(busy_3), .err(err_3)
   );

   pc_fetch_seq #(.WIDTH(8), .BURST_LEN(0), .GNT_TIMEOUT(15)) u_b0 (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
      .jump_req(jump_req), .jump_addr(jump_addr), .bus_gnt(bus_gnt),
      .pc_q(q_0), .pc_en(en_0), .pc_load(ld_0), .pc_load_val(lv_0),
      .pc_oe(oe_0), .bus_req(req_0), .fetch_valid(fv_0),
      .fetch_addr(fa_0), .busy(busy_0), .err(err_0)
   );

   // prog_counter8 behaviour: load has priority over enable.
   always_ff @(posedge clk or negedge pc_rst_n) begin
      if (!pc_rst_n)   q_3 <= 8'h00;
      else if (ld_3)   q_3 <= lv_3;
      else if (en_3)   q_3 <= q_3 + 8'h01;
   end

   always_ff @(posedge clk or negedge pc_rst_n) begin
      if (!pc_rst_n)   q_0 <= 8'h00;
      else if (ld_0)   q_0 <= lv_0;
      else if (en_0)   q_0 <= q_0 + 8'h01;
   end

   // pc_en and pc_load must never be high together.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ((en_0 && ld_0) || (en_3 && ld_3)) begin
            errors++;
            $display("FAIL en_ld_excl: en0=%b ld0=%b en3=%b ld3=%b", en_0, ld_0, en_3, ld_3);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // {busy, bus_req, pc_oe, fetch_valid, pc_en, pc_load}
   localparam logic [5:0] F_IDL = 6'b000000;
   localparam logic [5:0] F_REQ = 6'b110000;
   localparam logic [5:0] F_DRV = 6'b111100;
   localparam logic [5:0] F_STP = 6'b100010;
   localparam logic [5:0] F_LD  = 6'b100001;

   typedef struct packed {
      logic        s;
      logic        j;
      logic [7:0]  ja;
      logic        g;
      logic [21:0] exp;   // {flags[5:0], load_val[7:0], fetch_addr[7:0]}
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic s, input logic j, input logic [7:0] ja,
                               input logic g, input logic [5:0] fl,
                               input logic [7:0] lv, input logic [7:0] a);
      vec_t v;
      v.s   = s;
      v.j   = j;
      v.ja  = ja;
      v.g   = g;
      v.exp = {fl, lv, a};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      pc_rst_n  = 1'b0;
      start     = 1'b0;
      halt      = 1'b0;
      jump_req  = 1'b0;
      jump_addr = 8'h00;
      bus_gnt   = 1'b0;
      #1;
      chk("reset_b3", {24'h0, busy_3, req_3, oe_3, fv_3, en_3, ld_3, err_3, lv_3, fa_3}, 32'h0);
      chk("reset_b0", {24'h0, busy_0, req_0, oe_0, fv_0, en_0, ld_0, err_0, lv_0, fa_0}, 32'h0);
      @(negedge clk);
      rst_n    = 1'b1;
      pc_rst_n = 1'b1;
   endtask

   // Start an unbounded burst with the grant held; returns at the REQ negedge.
   task automatic start_burst();
      @(negedge clk);
      start   = 1'b1;
      bus_gnt = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_fv(output logic [7:0] a);
      bit found = 1'b0;
      a = 8'h00;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         #1;
         if (fv_0 === 1'b1) begin
            found = 1'b1;
            a = fa_0;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_fv: no fetch_valid within 20 cycles");
      end
   endtask

   initial begin
      logic [7:0] a;

      // Bounded burst of 3 from 00, then jump A5 + start together.
      tbl.push_back(mk(1, 0, 8'h00, 1, F_IDL, 8'h00, 8'h00));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_REQ, 8'h00, 8'h00));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_DRV, 8'h00, 8'h00));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_STP, 8'h00, 8'h00));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_REQ, 8'h00, 8'h01));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_DRV, 8'h00, 8'h01));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_STP, 8'h00, 8'h01));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_REQ, 8'h00, 8'h02));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_DRV, 8'h00, 8'h02));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_STP, 8'h00, 8'h02));
      tbl.push_back(mk(1, 1, 8'hA5, 1, F_IDL, 8'h00, 8'h03));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_LD,  8'hA5, 8'h03));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_REQ, 8'h00, 8'hA5));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_DRV, 8'h00, 8'hA5));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_STP, 8'h00, 8'hA5));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_REQ, 8'h00, 8'hA6));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_DRV, 8'h00, 8'hA6));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_STP, 8'h00, 8'hA6));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_REQ, 8'h00, 8'hA7));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_DRV, 8'h00, 8'hA7));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_STP, 8'h00, 8'hA7));
      tbl.push_back(mk(0, 0, 8'h00, 1, F_IDL, 8'h00, 8'hA8));

      do_reset();
      foreach (tbl[i]) begin
         @(negedge clk);
         start     = tbl[i].s;
         jump_req  = tbl[i].j;
         jump_addr = tbl[i].ja;
         bus_gnt   = tbl[i].g;
         #1;
         checks++;
         if ({busy_3, req_3, oe_3, fv_3, en_3, ld_3, lv_3, fa_3} !== tbl[i].exp) begin
            errors++;
            $display("FAIL vec[%0d]: got %h expected %h", i,
                     {busy_3, req_3, oe_3, fv_3, en_3, ld_3, lv_3, fa_3}, tbl[i].exp);
         end
      end

      // Mid-burst jump: jump to 40 during the fetch of 02.
      do_reset();
      start_burst();
      wait_fv(a); chk("mj_f0", {24'h0, a}, 32'h00);
      wait_fv(a); chk("mj_f1", {24'h0, a}, 32'h01);
      wait_fv(a); chk("mj_f2", {24'h0, a}, 32'h02);
      jump_req  = 1'b1;
      jump_addr = 8'h40;
      @(negedge clk);
      jump_req  = 1'b0;
      #1;
      chk("mj_step", {22'h0, en_0, ld_0, lv_0}, {22'h0, 2'b01, 8'h40});
      wait_fv(a); chk("mj_f3", {24'h0, a}, 32'h40);
      wait_fv(a); chk("mj_f4", {24'h0, a}, 32'h41);

      // Grant revoked during DRIVE: same address refetched.
      do_reset();
      start_burst();
      wait_fv(a); chk("gr_f0", {24'h0, a}, 32'h00);
      bus_gnt = 1'b0;
      #1;
      chk("gr_drop", {29'h0, oe_0, fv_0, req_0}, 32'h1);
      @(negedge clk);
      #1;
      chk("gr_req", {19'h0, busy_0, req_0, en_0, ld_0, fv_0, fa_0}, {19'h0, 5'b11000, 8'h00});
      bus_gnt = 1'b1;
      wait_fv(a); chk("gr_refetch", {24'h0, a}, 32'h00);
      wait_fv(a); chk("gr_next", {24'h0, a}, 32'h01);

      // Halt during REQ of the 5th fetch.
      do_reset();
      start_burst();
      for (int k = 0; k < 4; k++) begin
         wait_fv(a);
         chk("ht_fetch", {24'h0, a}, k);
      end
      @(negedge clk);               // STEP
      @(negedge clk);               // REQ of 5th fetch
      halt = 1'b1;
      #1;
      chk("ht_req", {29'h0, busy_0, req_0, fv_0}, 32'h6);
      @(negedge clk);
      halt = 1'b0;
      #1;
      chk("ht_f4", {23'h0, fv_0, fa_0}, {23'h0, 1'b1, 8'h04});
      @(negedge clk);
      #1;
      chk("ht_step", {31'h0, en_0}, 32'h1);
      @(negedge clk);
      #1;
      chk("ht_idle", {23'h0, busy_0, fa_0}, {23'h0, 1'b0, 8'h05});
      @(negedge clk);
      #1;
      chk("ht_stay", {31'h0, busy_0}, 32'h0);

      // Asynchronous reset while a jump is being applied.
      do_reset();
      start_burst();
      wait_fv(a); chk("ar_f0", {24'h0, a}, 32'h00);
      jump_req  = 1'b1;
      jump_addr = 8'h77;
      @(negedge clk);
      jump_req  = 1'b0;
      #1;
      chk("ar_step", {23'h0, ld_0, lv_0}, {23'h0, 1'b1, 8'h77});
      rst_n = 1'b0;
      #1;
      chk("ar_outs", {24'h0, busy_0, req_0, oe_0, fv_0, en_0, ld_0, err_0, |lv_0}, 32'h0);
      chk("ar_q", {24'h0, fa_0}, 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_fv(a); chk("ar_nojump", {24'h0, a}, 32'h00);

      // Grant never given.
      do_reset();
      @(negedge clk);
      bus_gnt = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;               // REQ cycle 1
      repeat (14) @(negedge clk);   // REQ cycle 15
      #1;
      chk("to_req15", {31'h0, busy_0}, 32'h1);
      @(negedge clk);
      #1;
`ifdef PC_FETCH_TIMEOUT_EN
      chk("to_abort", {30'h0, busy_0, err_0}, 32'h1);
      @(negedge clk);
      #1;
      chk("to_sticky", {30'h0, busy_0, err_0}, 32'h1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("to_clear", {30'h0, busy_0, err_0}, 32'h2);
`else
      chk("to_wait", {30'h0, busy_0, err_0}, 32'h2);
      repeat (20) @(negedge clk);
      #1;
      chk("to_wait_long", {29'h0, busy_0, req_0, err_0}, 32'h6);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
